alu_cmp_unit: RTL and testbench

RV32I integer datapath core for the execute stage: a 32-bit ALU (arithmetic, logic, shifts) and a 32-bit branch/set comparator, both driven from the stage's operand muxes. Both results are available combinationally for same-cycle use (branch resolution, PC target, SLT/SLTU writeback) and through an optional enabled output register. The ALU and comparator are separate sub-functions; in the pipeline the comparator is instanced twice (ALU-operand compare, raw forwarded rs1/rs2 compare).

---
 rtl/rv32i_types.sv | 26 ++
 rtl/alu.sv | 29 ++
 rtl/cmp.sv | 33 +++
 rtl/alu_cmp_unit.sv | 48 ++++
 tb/tb_alu_cmp_unit.sv | 122 ++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I execute-stage types.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops_t;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub, logic, shifts.
module alu
  import rv32i_types::*;
(
  input  alu_ops_t  aluop,
  input  rv32i_word a,
  input  rv32i_word b,
  output rv32i_word f
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    f = '0;
    unique case (aluop)
      alu_add: f = a + b;
      alu_sll: f = a << shamt;
      alu_sra: f = rv32i_word'($signed(a) >>> shamt);
      alu_sub: f = a - b;
      alu_xor: f = a ^ b;
      alu_srl: f = a >> shamt;
      alu_or:  f = a | b;
      alu_and: f = a & b;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/cmp.sv
// Combinational branch/set comparator.
module cmp
  import rv32i_types::*;
(
  input  branch_funct3_t cmpop,
  input  rv32i_word      a,
  input  rv32i_word      b,
  output logic           br_en
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    br_en = 1'b0;
    case (cmpop)
      beq:     br_en = eq;
      bne:     br_en = !eq;
      blt:     br_en = lt_s;
      bge:     br_en = !lt_s;
      bltu:    br_en = lt_u;
      bgeu:    br_en = !lt_u;
      // funct3 010/011 have no branch meaning
      default: br_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmp_unit.sv
// Execute-stage ALU + comparator with optional enabled output register.
module alu_cmp_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  aluop,
  input  logic [2:0]  cmpop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        en,
  output logic [31:0] f,
  output logic        br_en,
  output logic [31:0] f_q,
  output logic        br_en_q
);

  rv32i_word f_d;
  logic      br_en_d;

  alu u_alu (
    .aluop (alu_ops_t'(aluop)),
    .a     (a),
    .b     (b),
    .f     (f_d)
  );

  cmp u_cmp (
    .cmpop (branch_funct3_t'(cmpop)),
    .a     (a),
    .b     (b),
    .br_en (br_en_d)
  );

  assign f     = f_d;
  assign br_en = br_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q     <= '0;
      br_en_q <= 1'b0;
    end else if (en) begin
      f_q     <= f_d;
      br_en_q <= br_en_d;
    end
  end

endmodule

// File: tb/tb_alu_cmp_unit.sv
// Directed-vector bench for alu_cmp_unit.
module tb_alu_cmp_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  aluop;
  logic [2:0]  cmpop;
  logic [31:0] a;
  logic [31:0] b;
  logic        en;
  logic [31:0] f;
  logic        br_en;
  logic [31:0] f_q;
  logic        br_en_q;

  int n_run;
  int n_fail;

  alu_cmp_unit dut (
    .clk     (clk),
    .rst     (rst),
    .aluop   (aluop),
    .cmpop   (cmpop),
    .a       (a),
    .b       (b),
    .en      (en),
    .f       (f),
    .br_en   (br_en),
    .f_q     (f_q),
    .br_en_q (br_en_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic alu_v(input string tag, input logic [2:0] op,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] exp);
    aluop = op; a = va; b = vb;
    #1;
    chk(tag, f, exp);
  endtask

  task automatic cmp_v(input string tag, input logic [2:0] op,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic exp);
    cmpop = op; a = va; b = vb;
    #1;
    chk(tag, {31'b0, br_en}, {31'b0, exp});
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b0;
    aluop = 3'b000; cmpop = 3'b000;
    a = 32'd0; b = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_f_q", f_q, 32'h0);
    chk("rst_br_q", {31'b0, br_en_q}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    alu_v("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_v("sub_wrap", 3'b011, 32'h0, 32'h1, 32'hFFFF_FFFF);
    alu_v("sra_b5", 3'b010, 32'h8000_0000, 32'h21, 32'hC000_0000);
    alu_v("srl_b5", 3'b101, 32'h8000_0000, 32'h21, 32'h4000_0000);
    alu_v("sll_b5", 3'b001, 32'h1, 32'h21, 32'h2);
    alu_v("xor", 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_v("or", 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu_v("and", 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_v("sra_pos", 3'b010, 32'h7000_0000, 32'h4, 32'h0700_0000);

    cmp_v("blt", 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1);
    cmp_v("bltu", 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0);
    cmp_v("bge", 3'b101, 32'hFFFF_FFFF, 32'h1, 1'b0);
    cmp_v("bgeu", 3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1);
    cmp_v("beq", 3'b000, 32'd5, 32'd5, 1'b1);
    cmp_v("bne", 3'b001, 32'd5, 32'd5, 1'b0);
    cmp_v("beq_ne", 3'b000, 32'd5, 32'd6, 1'b0);
    cmp_v("bne_ne", 3'b001, 32'd5, 32'd6, 1'b1);
    cmp_v("undef010", 3'b010, 32'd5, 32'd5, 1'b0);
    cmp_v("undef011", 3'b011, 32'd1, 32'd5, 1'b0);
    cmp_v("bge_eq", 3'b101, 32'd7, 32'd7, 1'b1);

    @(negedge clk);
    aluop = 3'b000; cmpop = 3'b001;
    a = 32'd3; b = 32'd4; en = 1'b1;
    @(posedge clk); #1;
    chk("reg_add", f_q, 32'd7);
    chk("reg_br", {31'b0, br_en_q}, 32'h1);

    @(negedge clk);
    en = 1'b0; a = 32'd10; b = 32'd10;
    @(posedge clk); #1;
    chk("hold_f_q", f_q, 32'd7);
    chk("hold_br_q", {31'b0, br_en_q}, 32'h1);
    chk("comb_f", f, 32'd20);

    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    #1;
    chk("f_in_rst", f, 32'd20);
    @(posedge clk); #1;
    chk("rst_en_f_q", f_q, 32'h0);
    chk("rst_en_br_q", {31'b0, br_en_q}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
